// File: rtl/afifo_pkg.sv
// Shared FIFO package: default widths, the default data word type and the
// count-width helper used by the FIFO family.
package afifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  localparam int CNT_W_DEF  = $clog2(DEPTH_DEF) + 1;

  typedef logic [DATA_W_DEF-1:0] data_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module fifo_mem_dp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; a flushed or reset FIFO never reads stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT reads.
module sync_fifo_flags
  import afifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_ok;
  logic              wr_ok;

  assign empty        = (count_q == CW'(0));
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AFULL_TH));
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a write when a read in the same cycle frees a slot.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok & ~clr),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_ok && !rd_ok) begin
        count_q <= count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count_q <= count_q - CW'(1);
      end
      if (wr_en && !wr_ok) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset looks clean.
      assign data_out = empty ? '0 : mem_rdata;
    end else begin : g_std
      logic [DATA_W-1:0] data_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q <= '0;
        end else if (clr) begin
          data_q <= '0;
        end else if (rd_ok) begin
          data_q <= mem_rdata;
        end
      end

      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a standard-mode and an FWFT instance
// share the same stimulus; expected values are hand-computed.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;

  logic [7:0] data_out, f_data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] count, f_count;

  int vector_count = 0;
  int miss_count   = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b0)) dut_std (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after an edge, then sample 1ns after the next edge.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    clr     = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    #12;
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_aempty", 32'(almost_empty), 1);
    checkOutput("rst_afull", 32'(almost_full), 0);
    checkOutput("rst_ovf", 32'(overflow), 0);
    checkOutput("rst_unf", 32'(underflow), 0);
    checkOutput("rst_dout", 32'(data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("fill_count", 32'(count), 32'(i));
      checkOutput("fill_afull", 32'(almost_full), (i >= 14) ? 1 : 0);
      checkOutput("fill_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
      checkOutput("fill_full", 32'(full), (i == 16) ? 1 : 0);
      checkOutput("fill_ovf", 32'(overflow), 0);
    end

    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("ovf_flag", 32'(overflow), 1);
    checkOutput("ovf_count", 32'(count), 16);

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_data", 32'(data_out), 32'(i));
      checkOutput("drain_count", 32'(count), 32'(16 - i));
    end
    checkOutput("drain_empty", 32'(empty), 1);
    checkOutput("drain_ovf_sticky", 32'(overflow), 1);

    // Write and read together while empty
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("unf_count", 32'(count), 1);
    checkOutput("unf_flag", 32'(underflow), 1);
    checkOutput("unf_dout_hold", 32'(data_out), 32'h10);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf_next_read", 32'(data_out), 32'h55);
    checkOutput("unf_next_count", 32'(count), 0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(overflow), 0);
    checkOutput("clr_unf", 32'(underflow), 0);
    checkOutput("clr_dout", 32'(data_out), 0);

    // Full pass-through
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    end
    checkOutput("pt_full", 32'(full), 1);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("pt_count", 32'(count), 16);
    checkOutput("pt_ovf", 32'(overflow), 0);
    checkOutput("pt_dout", 32'(data_out), 32'h01);
    for (int i = 2; i <= 17; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("pt_drain", 32'(data_out), (i == 17) ? 32'h77 : 32'(i));
    end
    checkOutput("pt_empty", 32'(empty), 1);

    // Five entries plus a sticky overflow, then a flush that also carries a write
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("pre_clr_count", 32'(count), 5);
    checkOutput("pre_clr_ovf", 32'(overflow), 1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkOutput("clrw_count", 32'(count), 0);
    checkOutput("clrw_ovf", 32'(overflow), 0);
    checkOutput("clrw_empty", 32'(empty), 1);
    checkOutput("clrw_dout", 32'(data_out), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("clrw_ignored_unf", 32'(underflow), 1);
    checkOutput("clrw_ignored_count", 32'(count), 0);

    // Async reset mid-stream, asserted away from any rising edge
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h63, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pre_rst_dout", 32'(data_out), 32'h61);
    checkOutput("pre_rst_count", 32'(count), 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("arst_count", 32'(count), 0);
    checkOutput("arst_empty", 32'(empty), 1);
    checkOutput("arst_aempty", 32'(almost_empty), 1);
    checkOutput("arst_unf", 32'(underflow), 0);
    checkOutput("arst_dout", 32'(data_out), 0);
    checkOutput("arst_f_count", 32'(f_count), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First-word-fall-through instance
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    checkOutput("fwft_first", 32'(f_data_out), 32'h3C);
    checkOutput("fwft_nonempty", 32'(f_empty), 0);
    applyStimulus(1'b1, 8'h4D, 1'b0, 1'b0);
    checkOutput("fwft_head_hold", 32'(f_data_out), 32'h3C);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fwft_pop_next", 32'(f_data_out), 32'h4D);
    checkOutput("fwft_pop_count", 32'(f_count), 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fwft_empty", 32'(f_empty), 1);
    checkOutput("fwft_unf", 32'(f_underflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
